// File: rtl/i2c_reg_target.sv
// I2C target with a small write/read register file and auto-incrementing pointer.
// SCL/SDA are oversampled on clk; SDA is driven open-drain (low or released).
module i2c_reg_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1001010,
    parameter int         NUM_REGS   = 4,
    localparam int        IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic                  wr_strobe,
    output logic [IDX_W-1:0]      wr_index,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t           state, state_n;
    logic [1:0]       scl_ff, sda_ff;
    logic             scl_d, sda_d;
    logic             scl_s, sda_s;
    logic             rise, fall, start_c, stop_c, last;
    logic [6:0]       sh;
    logic [7:0]       byte_in;
    logic [6:0]       tx;
    logic [3:0]       cnt;
    logic             rw, ack_on, sda_low;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], scl};
            sda_ff <= {sda_ff[0], sda};
            scl_d  <= scl_ff[1];
            sda_d  <= sda_ff[1];
        end
    end

    assign scl_s   = scl_ff[1];
    assign sda_s   = sda_ff[1];
    assign rise    = scl_s & ~scl_d;
    assign fall    = ~scl_s & scl_d;
    assign start_c = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_c  = scl_s & scl_d & ~sda_d & sda_s;
    assign last    = (cnt == 4'd7);
    assign byte_in = {sh, sda_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (stop_c) begin
            state_n = IDLE;
        end else if (start_c) begin
            state_n = ADDR;
        end else begin
            unique case (state)
                ADDR:
                    if (rise && last)
                        state_n = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK:
                    if (fall && ack_on) state_n = rw ? RDATA : PTR;
                PTR:
                    if (rise && last) state_n = PTR_ACK;
                PTR_ACK, WDATA_ACK:
                    if (fall && ack_on) state_n = WDATA;
                WDATA:
                    if (rise && last) state_n = WDATA_ACK;
                RDATA:
                    if (fall && cnt == 4'd8) state_n = RACK;
                RACK:
                    if (rise && sda_s)        state_n = IGNORE;
                    else if (fall && ack_on)  state_n = RDATA;
                default: ;
            endcase
        end
    end

    // ACK states drive low from the first SCL fall to the second; ack_on marks the phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh        <= '0;
            tx        <= '0;
            cnt       <= '0;
            rw        <= 1'b0;
            ack_on    <= 1'b0;
            sda_low   <= 1'b0;
            busy      <= 1'b0;
            ptr       <= '0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (rise) sh <= byte_in[6:0];
            if (stop_c) begin
                sda_low <= 1'b0;
                ack_on  <= 1'b0;
                busy    <= 1'b0;
                cnt     <= '0;
            end else if (start_c) begin
                sda_low <= 1'b0;
                ack_on  <= 1'b0;
                cnt     <= '0;
            end else begin
                unique case (state)
                    ADDR:
                        if (rise) begin
                            cnt <= cnt + 4'd1;
                            if (last) begin
                                cnt  <= '0;
                                rw   <= byte_in[0];
                                busy <= (byte_in[7:1] == SLAVE_ADDR);
                            end
                        end
                    ADDR_ACK, PTR_ACK, WDATA_ACK:
                        if (fall) begin
                            ack_on  <= ~ack_on;
                            sda_low <= ~ack_on;
                            if (ack_on && state == ADDR_ACK && rw) begin
                                tx      <= regs[ptr][6:0];
                                sda_low <= ~regs[ptr][7];
                            end
                        end
                    PTR:
                        if (rise) begin
                            cnt <= cnt + 4'd1;
                            if (last) begin
                                cnt <= '0;
                                ptr <= byte_in[IDX_W-1:0];
                            end
                        end
                    WDATA:
                        if (rise) begin
                            cnt <= cnt + 4'd1;
                            if (last) begin
                                cnt       <= '0;
                                regs[ptr] <= byte_in;
                                wr_strobe <= 1'b1;
                                wr_index  <= ptr;
                                ptr       <= ptr + 1'b1;
                            end
                        end
                    RDATA:
                        if (rise) begin
                            cnt <= cnt + 4'd1;
                        end else if (fall) begin
                            if (cnt == 4'd8) begin
                                sda_low <= 1'b0;
                                cnt     <= '0;
                            end else begin
                                tx      <= {tx[5:0], 1'b0};
                                sda_low <= ~tx[6];
                            end
                        end
                    RACK:
                        if (rise) begin
                            if (!sda_s) begin
                                ack_on <= 1'b1;
                                ptr    <= ptr + 1'b1;
                            end else begin
                                busy <= 1'b0;
                            end
                        end else if (fall && ack_on) begin
                            ack_on  <= 1'b0;
                            tx      <= regs[ptr][6:0];
                            sda_low <= ~regs[ptr][7];
                        end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        regs_out = '0;
        for (int k = 0; k < NUM_REGS; k++) regs_out[8*k +: 8] = regs[k];
    end

    assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged master, vector table,
// directed corner sequences and randomized transfers against a register model.
module tb_i2c_reg_target;
    localparam int Q = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda_low = 1'b0;
    wire         sda_bus;
    logic [31:0] regs_out;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic        busy;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_reg_target dut (
        .clk(clk), .reset(rst_n), .scl(m_scl), .sda(sda_bus),
        .regs_out(regs_out), .wr_strobe(wr_strobe),
        .wr_index(wr_index), .busy(busy)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] strobe_q[$];
    logic [1:0] exp_q[$];
    bit         tgt_low_seen, busy_seen;
    logic [7:0] m_regs [4];
    int         m_ptr;

    always @(negedge clk) begin
        if (wr_strobe) strobe_q.push_back(wr_index);
        if (rst_n && !m_sda_low && sda_bus === 1'b0) tgt_low_seen <= 1'b1;
        if (busy) busy_seen <= 1'b1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; tick();
        m_scl = 1'b1;     tick();
        m_sda_low = 1'b1; tick();
        m_scl = 1'b0;     tick();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; tick();
        m_scl = 1'b1;     tick();
        m_sda_low = 1'b0; tick();
    endtask

    task automatic wbit(input bit b);
        m_sda_low = ~b; tick();
        m_scl = 1'b1;   tick(2);
        m_scl = 1'b0;   tick();
    endtask

    task automatic rbit(output bit b);
        m_sda_low = 1'b0; tick();
        m_scl = 1'b1;     tick();
        b = (sda_bus !== 1'b0);
        tick();
        m_scl = 1'b0;     tick();
    endtask

    task automatic wbyte(input logic [7:0] d, output bit ack);
        bit nack;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(nack);
        ack = !nack;
    endtask

    task automatic rbyte(output logic [7:0] d, input bit mack);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(!mack);
    endtask

    function automatic logic [31:0] model_pack();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    task automatic clear_mon();
        strobe_q.delete();
        exp_q.delete();
        tgt_low_seen = 1'b0;
        busy_seen = 1'b0;
    endtask

    task automatic chk_strobes(input string nm);
        chk({nm, "_cnt"}, 32'(strobe_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < strobe_q.size() && i < exp_q.size(); i++)
            chk({nm, "_idx"}, 32'(strobe_q[i]), 32'(exp_q[i]));
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  ptr;
        logic [7:0]  data;
        bit          ack;
        logic [1:0]  idx;
        logic [31:0] regs;
    } vec_t;

    vec_t tbl[4];

    initial begin
        bit         a0, a1, a2;
        logic [7:0] d0, d1;

        tbl[0] = '{8'h94, 8'h01, 8'hA6, 1'b1, 2'd1, 32'h0000_A600};
        tbl[1] = '{8'h94, 8'h02, 8'hE4, 1'b1, 2'd2, 32'h00E4_A600};
        tbl[2] = '{8'h96, 8'h00, 8'h55, 1'b0, 2'd0, 32'h00E4_A600};
        tbl[3] = '{8'h94, 8'hFC, 8'h3C, 1'b1, 2'd0, 32'h00E4_A63C};

        repeat (3) @(negedge clk);
        chk("rst_regs", regs_out, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobe", 32'(wr_strobe), 32'h0);
        chk("rst_index", 32'(wr_index), 32'h0);
        chk("rst_sda", 32'(sda_bus), 32'h1);
        rst_n = 1'b1;
        tick(2);

        for (int r = 0; r < 4; r++) begin
            clear_mon();
            if (tbl[r].ack) exp_q.push_back(tbl[r].idx);
            i2c_start();
            wbyte(tbl[r].addr, a0);
            chk("tbl_addr_ack", 32'(a0), 32'(tbl[r].ack));
            chk("tbl_busy_mid", 32'(busy), 32'(tbl[r].ack));
            wbyte(tbl[r].ptr, a1);
            wbyte(tbl[r].data, a2);
            chk("tbl_ptr_ack", 32'(a1), 32'(tbl[r].ack));
            chk("tbl_data_ack", 32'(a2), 32'(tbl[r].ack));
            i2c_stop();
            tick();
            chk("tbl_regs", regs_out, tbl[r].regs);
            chk_strobes("tbl_strobe");
            chk("tbl_busy_end", 32'(busy), 32'h0);
            if (!tbl[r].ack) begin
                chk("tbl_no_drive", 32'(tgt_low_seen), 32'h0);
                chk("tbl_busy_never", 32'(busy_seen), 32'h0);
            end
        end

        // read with auto-increment across a repeated START
        clear_mon();
        i2c_start();
        wbyte(8'h94, a0);
        wbyte(8'h01, a1);
        i2c_start();
        wbyte(8'h95, a2);
        chk("rd_acks", {29'd0, a0, a1, a2}, 32'h7);
        rbyte(d0, 1'b1);
        chk("rd_busy", 32'(busy), 32'h1);
        rbyte(d1, 1'b0);
        chk("rd_byte0", 32'(d0), 32'hA6);
        chk("rd_byte1", 32'(d1), 32'hE4);
        i2c_stop();
        tick();
        chk("rd_busy_end", 32'(busy), 32'h0);
        chk("rd_bus_idle", 32'(sda_bus), 32'h1);
        chk_strobes("rd_strobe");

        // pointer wrap on write
        clear_mon();
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        i2c_start();
        wbyte(8'h94, a0);
        wbyte(8'h03, a1);
        wbyte(8'h11, a2);
        wbyte(8'h22, a0);
        i2c_stop();
        tick();
        chk("wrap_regs", regs_out, 32'h11E4_A622);
        chk_strobes("wrap_strobe");

        // STOP after a partial data byte
        clear_mon();
        i2c_start();
        wbyte(8'h94, a0);
        wbyte(8'h02, a1);
        for (int i = 0; i < 5; i++) wbit(i[0] == 1'b0);
        i2c_stop();
        tick();
        chk("part_regs", regs_out, 32'h11E4_A622);
        chk_strobes("part_strobe");
        chk("part_busy", 32'(busy), 32'h0);

        // reset while the target drives a read bit low (reg0 = 0x22, MSB 0)
        i2c_start();
        wbyte(8'h94, a0);
        wbyte(8'h00, a1);
        i2c_start();
        wbyte(8'h95, a2);
        chk("rst_rd_ack", 32'(a2), 32'h1);
        chk("rst_rd_drive", 32'(sda_bus), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_rd_sda", 32'(sda_bus), 32'h1);
        chk("rst_rd_busy", 32'(busy), 32'h0);
        chk("rst_rd_regs", regs_out, 32'h0);
        tick();
        m_scl = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(2);
        clear_mon();
        exp_q.push_back(2'd1);
        i2c_start();
        wbyte(8'h94, a0);
        wbyte(8'h01, a1);
        wbyte(8'h5A, a2);
        i2c_stop();
        tick();
        chk("post_rst_acks", {29'd0, a0, a1, a2}, 32'h7);
        chk("post_rst_regs", regs_out, 32'h0000_5A00);
        chk_strobes("post_rst_strobe");

        m_regs = '{8'h00, 8'h5A, 8'h00, 8'h00};
        m_ptr  = 2;

        for (int t = 0; t < 14; t++) begin
            int         kind, n;
            logic [7:0] p, d, ab;
            logic [6:0] wa;
            kind = $urandom_range(0, 9);
            n    = $urandom_range(1, 3);
            clear_mon();
            if (kind <= 4) begin
                p = 8'($urandom);
                i2c_start();
                wbyte(8'h94, a0);
                chk("rnd_w_addr_ack", 32'(a0), 32'h1);
                wbyte(p, a1);
                chk("rnd_w_ptr_ack", 32'(a1), 32'h1);
                m_ptr = p % 4;
                for (int j = 0; j < n; j++) begin
                    d = 8'($urandom);
                    wbyte(d, a2);
                    chk("rnd_w_data_ack", 32'(a2), 32'h1);
                    exp_q.push_back(2'(m_ptr));
                    m_regs[m_ptr] = d;
                    m_ptr = (m_ptr + 1) % 4;
                end
                i2c_stop();
                tick();
                chk_strobes("rnd_w_strobe");
            end else if (kind <= 8) begin
                i2c_start();
                if ($urandom_range(0, 1) == 1) begin
                    p = 8'($urandom);
                    wbyte(8'h94, a0);
                    chk("rnd_r_set_ack", 32'(a0), 32'h1);
                    wbyte(p, a1);
                    chk("rnd_r_ptr_ack", 32'(a1), 32'h1);
                    m_ptr = p % 4;
                    i2c_start();
                end
                wbyte(8'h95, a2);
                chk("rnd_r_addr_ack", 32'(a2), 32'h1);
                for (int j = 0; j < n; j++) begin
                    rbyte(d, j != n - 1);
                    chk("rnd_r_byte", 32'(d), 32'(m_regs[m_ptr]));
                    if (j != n - 1) m_ptr = (m_ptr + 1) % 4;
                end
                i2c_stop();
                tick();
                chk("rnd_r_busy", 32'(busy), 32'h0);
            end else begin
                wa = 7'($urandom_range(0, 127));
                if (wa == 7'h4A) wa = 7'h4B;
                ab = {wa, 1'($urandom)};
                i2c_start();
                wbyte(ab, a0);
                wbyte(8'($urandom), a1);
                wbyte(8'($urandom), a2);
                i2c_stop();
                tick();
                chk("rnd_x_acks", {29'd0, a0, a1, a2}, 32'h0);
                chk("rnd_x_no_drive", 32'(tgt_low_seen), 32'h0);
                chk("rnd_x_busy", 32'(busy_seen), 32'h0);
                chk_strobes("rnd_x_strobe");
            end
            chk("rnd_regs", regs_out, model_pack());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
